// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID inputs, forward sources and EX-side outputs.
// The pipeline (master) drives ID and forward sources; the stage (slave) drives EX outputs.
interface id_ex_stage_if #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              flush;
  logic              id_valid;
  logic [4:0]        id_rs_addr;
  logic [4:0]        id_rt_addr;
  logic              id_uses_rt;
  logic [4:0]        id_wt_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [31:0]       id_rdata_a;
  logic [31:0]       id_rdata_b;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              exmem_reg_write;
  logic [4:0]        exmem_wt_addr;
  logic [31:0]       exmem_result;
  logic              memwb_reg_write;
  logic [4:0]        memwb_wt_addr;
  logic [31:0]       memwb_wt_data;
  logic              stall;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [4:0]        ex_wt_addr;
  logic [31:0]       ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_op_a;
  logic [31:0]       ex_op_b;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, id_valid, id_rs_addr, id_rt_addr, id_uses_rt, id_wt_addr,
           id_reg_write, id_mem_read, id_rdata_a, id_rdata_b, id_imm, id_ctrl,
           exmem_reg_write, exmem_wt_addr, exmem_result,
           memwb_reg_write, memwb_wt_addr, memwb_wt_data,
    input  stall, ex_valid, ex_reg_write, ex_mem_read, ex_wt_addr, ex_imm,
           ex_ctrl, ex_op_a, ex_op_b, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  flush, id_valid, id_rs_addr, id_rt_addr, id_uses_rt, id_wt_addr,
           id_reg_write, id_mem_read, id_rdata_a, id_rdata_b, id_imm, id_ctrl,
           exmem_reg_write, exmem_wt_addr, exmem_result,
           memwb_reg_write, memwb_wt_addr, memwb_wt_data,
    output stall, ex_valid, ex_reg_write, ex_mem_read, ex_wt_addr, ex_imm,
           ex_ctrl, ex_op_a, ex_op_b, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use stall detection.
// Register file writes on negedge, so the third-older writer never needs forwarding.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

  logic              valid_q,     valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q,  mem_read_d;
  logic [AW-1:0]     wt_addr_q,   wt_addr_d;
  logic [AW-1:0]     rs_addr_q,   rs_addr_d;
  logic [AW-1:0]     rt_addr_q,   rt_addr_d;
  logic [DW-1:0]     rdata_a_q,   rdata_a_d;
  logic [DW-1:0]     rdata_b_q,   rdata_b_d;
  logic [DW-1:0]     imm_q,       imm_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              hz_c;
  logic              stall_c;
  logic [1:0]        fwd_a_c, fwd_b_c;
  logic [DW-1:0]     op_a_c, op_b_c;

  // Load in EX whose destination is a source of the instruction in ID.
  always_comb begin
    hz_c = valid_q && mem_read_q && (wt_addr_q != '0) && bus.id_valid &&
           ((bus.id_rs_addr == wt_addr_q) ||
            (bus.id_uses_rt && (bus.id_rt_addr == wt_addr_q)));
    stall_c = hz_c && !bus.flush;
  end

  // Next pipeline contents: flush or stall inject an all-zero bubble.
  always_comb begin
    valid_d     = bus.id_valid;
    reg_write_d = bus.id_valid && bus.id_reg_write;
    mem_read_d  = bus.id_valid && bus.id_mem_read;
    wt_addr_d   = bus.id_wt_addr;
    rs_addr_d   = bus.id_rs_addr;
    rt_addr_d   = bus.id_rt_addr;
    rdata_a_d   = bus.id_rdata_a;
    rdata_b_d   = bus.id_rdata_b;
    imm_d       = bus.id_imm;
    ctrl_d      = bus.id_ctrl;
    if (bus.flush || stall_c) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      wt_addr_d   = '0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      rdata_a_d   = '0;
      rdata_b_d   = '0;
      imm_d       = '0;
      ctrl_d      = '0;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      wt_addr_q   <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      wt_addr_q   <= wt_addr_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
    logic [1:0] sel;
    sel = FWD_REG;
    if (src != '0) begin
      if (bus.exmem_reg_write && (bus.exmem_wt_addr != '0) && (bus.exmem_wt_addr == src)) begin
        sel = FWD_EXMEM;
      end else if (bus.memwb_reg_write && (bus.memwb_wt_addr != '0) &&
                   (bus.memwb_wt_addr == src)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

  function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel, input logic [AW-1:0] src,
                                            input logic [DW-1:0] rdata);
    logic [DW-1:0] op;
    op = (src == '0) ? '0 : rdata;
    if (sel == FWD_EXMEM) begin
      op = bus.exmem_result;
    end else if (sel == FWD_MEMWB) begin
      op = bus.memwb_wt_data;
    end
    return op;
  endfunction

  // Operand forwarding on the registered source numbers; EX/MEM is the younger writer.
  always_comb begin
    fwd_a_c = fwd_sel(rs_addr_q);
    fwd_b_c = fwd_sel(rt_addr_q);
    op_a_c  = fwd_mux(fwd_a_c, rs_addr_q, rdata_a_q);
    op_b_c  = fwd_mux(fwd_b_c, rt_addr_q, rdata_b_q);
  end

  assign bus.stall        = stall_c;
  assign bus.ex_valid     = valid_q;
  assign bus.ex_reg_write = reg_write_q;
  assign bus.ex_mem_read  = mem_read_q;
  assign bus.ex_wt_addr   = wt_addr_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_ctrl      = ctrl_q;
  assign bus.ex_op_a      = op_a_c;
  assign bus.ex_op_b      = op_b_c;
  assign bus.fwd_a        = fwd_a_c;
  assign bus.fwd_b        = fwd_b_c;
  assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued when ID is driven
// and compared after the capturing edge; stall and counter are checked in place.
module tb_id_ex_stage;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        rw;
    logic        mr;
    logic [4:0]  wt;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] oa;
    logic [31:0] ob;
  } ex_exp_t;

  ex_exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_ex(input logic v, input logic rw, input logic mr, input logic [4:0] wt,
                         input logic [31:0] imm, input logic [7:0] ctrl,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] oa, input logic [31:0] ob);
    ex_exp_t e;
    e.v = v; e.rw = rw; e.mr = mr; e.wt = wt; e.imm = imm; e.ctrl = ctrl;
    e.fa = fa; e.fb = fb; e.oa = oa; e.ob = ob;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push_ex(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 8'd0, 2'd0, 2'd0, 32'd0, 32'd0);
  endtask

  task automatic pop_ex(input string tag);
    ex_exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_valid"},     32'(bus.ex_valid),     32'(e.v));
    chk({tag, "_reg_write"}, 32'(bus.ex_reg_write), 32'(e.rw));
    chk({tag, "_mem_read"},  32'(bus.ex_mem_read),  32'(e.mr));
    chk({tag, "_wt_addr"},   32'(bus.ex_wt_addr),   32'(e.wt));
    chk({tag, "_imm"},       bus.ex_imm,            e.imm);
    chk({tag, "_ctrl"},      32'(bus.ex_ctrl),      32'(e.ctrl));
    chk({tag, "_fwd_a"},     32'(bus.fwd_a),        32'(e.fa));
    chk({tag, "_fwd_b"},     32'(bus.fwd_b),        32'(e.fb));
    chk({tag, "_op_a"},      bus.ex_op_a,           e.oa);
    chk({tag, "_op_b"},      bus.ex_op_b,           e.ob);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ut, input logic [4:0] wt, input logic rw, input logic mr,
                        input logic [31:0] ra, input logic [31:0] rb,
                        input logic [31:0] imm, input logic [7:0] ctrl);
    bus.id_valid = v; bus.id_rs_addr = rs; bus.id_rt_addr = rt; bus.id_uses_rt = ut;
    bus.id_wt_addr = wt; bus.id_reg_write = rw; bus.id_mem_read = mr;
    bus.id_rdata_a = ra; bus.id_rdata_b = rb; bus.id_imm = imm; bus.id_ctrl = ctrl;
  endtask

  task automatic set_idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 8'd0);
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] ea, input logic [31:0] er,
                         input logic mw, input logic [4:0] ma, input logic [31:0] md);
    bus.exmem_reg_write = ew; bus.exmem_wt_addr = ea; bus.exmem_result = er;
    bus.memwb_reg_write = mw; bus.memwb_wt_addr = ma; bus.memwb_wt_data = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load $dst into EX (no forwarding active), checking its captured contents.
  task automatic load_into_ex(input logic [4:0] dst, input logic [31:0] ra, input string tag);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd1, 5'd0, 1'b0, dst, 1'b1, 1'b1, ra, 32'd0, 32'h4, 8'h21);
    push_ex(1'b1, 1'b1, 1'b1, dst, 32'h4, 8'h21, 2'd0, 2'd0, ra, 32'd0);
    tick();
    pop_ex(tag);
  endtask

  int exp_cnt;

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus.flush = 1'b0;
    set_idle();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3;
    chk("rst_ex_valid",  32'(bus.ex_valid),  32'd0);
    chk("rst_stall",     32'(bus.stall),     32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_op_a",      bus.ex_op_a,        32'd0);
    chk("rst_fwd_b",     32'(bus.fwd_b),     32'd0);
    chk("rst_imm",       bus.ex_imm,         32'd0);
    @(negedge clk);
    rst = 1'b0;

    // lw $2 then add $3,$2,$2: one stall, one bubble, then MEM/WB forwarding.
    load_into_ex(5'd2, 32'h10, "lw2");
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 32'h55, 32'h55, 32'h0, 8'h05);
    #1;
    chk("lu_stall", 32'(bus.stall), 32'd1);
    push_bubble();
    tick();
    set_fwd(1'b1, 5'd2, 32'h1000, 1'b0, 5'd0, 32'd0);
    #1;
    pop_ex("lu_bubble");
    chk("lu_stall_released", 32'(bus.stall), 32'd0);
    chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
    push_ex(1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 8'h05, 2'd1, 2'd1, 32'hAA, 32'hAA);
    tick();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hAA);
    set_idle();
    #1;
    pop_ex("lu_add");
    chk("lu_cnt_hold", 32'(bus.stall_cnt), 32'd1);

    // EX/MEM beats MEM/WB on the same register.
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 32'h33, 32'h44, 32'h8, 8'h11);
    push_ex(1'b1, 1'b1, 1'b0, 5'd7, 32'h8, 8'h11, 2'd2, 2'd0, 32'h1111_1111, 32'h44);
    tick();
    set_fwd(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222);
    set_idle();
    #1;
    pop_ex("prio");
    set_fwd(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222);
    #1;
    chk("prio_fwd_b_memwb", 32'(bus.fwd_b), 32'd1);
    chk("prio_op_b_memwb",  bus.ex_op_b,    32'h2222_2222);
    set_fwd(1'b0, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222);
    #1;
    chk("memwb_only_fwd_a", 32'(bus.fwd_a), 32'd1);
    chk("memwb_only_op_a",  bus.ex_op_a,    32'h2222_2222);

    // Register 0 is never forwarded and reads as zero.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h99, 32'h77, 32'h0, 8'h00);
    push_ex(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 8'h00, 2'd0, 2'd0, 32'd0, 32'd0);
    tick();
    set_fwd(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'h5);
    set_idle();
    #1;
    pop_ex("r0");

    // Flush coincident with a load-use hazard: bubble, no stall, counter unchanged.
    load_into_ex(5'd4, 32'h20, "lw4");
    set_id(1'b1, 5'd4, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 32'h1, 32'h2, 32'h0, 8'h33);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall), 32'd0);
    push_bubble();
    tick();
    bus.flush = 1'b0;
    set_idle();
    #1;
    pop_ex("flush_bubble");
    chk("flush_cnt", 32'(bus.stall_cnt), 32'd1);

    // rt only matters when the instruction reads it.
    load_into_ex(5'd7, 32'h30, "lw7a");
    set_id(1'b1, 5'd1, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0, 32'h1, 32'h2, 32'h7, 8'h44);
    #1;
    chk("addi_no_stall", 32'(bus.stall), 32'd0);
    push_ex(1'b1, 1'b1, 1'b0, 5'd8, 32'h7, 8'h44, 2'd0, 2'd0, 32'h1, 32'h2);
    tick();
    pop_ex("addi");
    load_into_ex(5'd7, 32'h30, "lw7b");
    set_id(1'b1, 5'd1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 32'h1, 32'h2, 32'hC, 8'h55);
    #1;
    chk("sw_stall", 32'(bus.stall), 32'd1);
    push_bubble();
    tick();
    pop_ex("sw_bubble");
    chk("sw_cnt", 32'(bus.stall_cnt), 32'd2);
    chk("sw_no_restall", 32'(bus.stall), 32'd0);

    // Counter saturates at all-ones.
    exp_cnt = 2;
    for (int i = 0; i < 5; i++) begin
      load_into_ex(5'd8, 32'h40, "lw8");
      set_id(1'b1, 5'd8, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 8'h66);
      #1;
      chk("sat_stall", 32'(bus.stall), 32'd1);
      push_bubble();
      tick();
      pop_ex("sat_bubble");
      exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
      chk("sat_cnt", 32'(bus.stall_cnt), 32'(exp_cnt));
    end

    // Asynchronous reset while stalling.
    load_into_ex(5'd9, 32'h50, "lw9");
    set_id(1'b1, 5'd9, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 8'h77);
    #1;
    chk("rst_mid_stall_pre", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_stall",     32'(bus.stall),       32'd0);
    chk("arst_valid",     32'(bus.ex_valid),    32'd0);
    chk("arst_mem_read",  32'(bus.ex_mem_read), 32'd0);
    chk("arst_wt_addr",   32'(bus.ex_wt_addr),  32'd0);
    chk("arst_op_a",      bus.ex_op_a,          32'd0);
    chk("arst_ctrl",      32'(bus.ex_ctrl),     32'd0);
    chk("arst_stall_cnt", 32'(bus.stall_cnt),   32'd0);
    tick();
    chk("arst_hold_valid", 32'(bus.ex_valid),  32'd0);
    chk("arst_hold_cnt",   32'(bus.stall_cnt), 32'd0);
    chk("arst_hold_stall", 32'(bus.stall),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the 5-stage CPU. It captures the register-file read data (rs/rt), immediate and decoded control at the end of ID and presents them to EX. EX operands are forwarded from EX/MEM and MEM/WB, and a load-use hazard produces a one-cycle stall plus bubble. It consumes the register file's read ports directly and relies on that file writing on negedge, so WB-to-ID needs no forwarding.

## Interface
- CTRL_W, 8, width of opaque ALU/branch/mem control bundle passed ID→EX
- CNT_W, 16, width of saturating stall counter
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  squash ID instruction (taken branch/jump resolved in EX)
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr  in  5 each  source register numbers
- id_uses_rt  in  1  instruction reads rt as operand (R-type, store, beq/bne)
- id_wt_addr  in  5  destination register
- id_reg_write, id_mem_read  in  1 each  writes GPR / is a load
- id_rdata_a, id_rdata_b  in  32 each  register file read data
- id_imm  in  32  sign/zero-extended immediate
- id_ctrl  in  CTRL_W  control bundle
- exmem_reg_write  in  1; exmem_wt_addr  in  5; exmem_result  in  32  EX/MEM forward source
- memwb_reg_write  in  1; memwb_wt_addr  in  5; memwb_wt_data  in  32  MEM/WB forward source (same values driving register file write port)
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid, ex_reg_write, ex_mem_read  out  1 each  registered
- ex_wt_addr  out  5; ex_imm  out  32; ex_ctrl  out  CTRL_W  registered
- ex_op_a, ex_op_b  out  32 each  forwarded operands (combinational from registered data)
- fwd_a, fwd_b  out  2 each  forward select: 0 reg, 1 MEM/WB, 2 EX/MEM
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Pipeline register (posedge): three cases, in priority order.
  - flush=1: load bubble (valid, reg_write, mem_read = 0; other fields = 0).
  - Else stall=1: load bubble.
  - Else: capture all id_* fields; ex_valid=id_valid. If id_valid=0, reg_write/mem_read are forced to 0.
- Load-use hazard: hz = ex_valid & ex_mem_read & (ex_wt_addr≠0) & id_valid & ((id_rs_addr==ex_wt_addr) | (id_uses_rt & id_rt_addr==ex_wt_addr)).
- stall = hz & ~flush (combinational). Flush wins; a squashed instruction never stalls.
- Forwarding, per operand, on the registered rs/rt:
  - EX/MEM (exmem_reg_write, addr≠0, addr match) has priority.
  - Else MEM/WB (same conditions).
  - Else registered rdata.
  - Register 0 is never forwarded; op is 0 when the registered rs/rt is 0.
- ex_op_b forwards on rt regardless of id_uses_rt. Immediate selection is EX's job.
- stall_cnt: +1 on each posedge where stall=1; holds at all-ones (no wrap).
- Third-older writer needs no forwarding: its negedge register-file write lands before the ID posedge capture.

## Timing
- Reset (async, immediate): ex_valid, ex_reg_write, ex_mem_read, ex_wt_addr, ex_imm, ex_ctrl, registered rs/rt/rdata, stall_cnt = 0.
  - Consequently ex_op_a = ex_op_b = 0, fwd_a = fwd_b = 0, stall = 0.
- Latency ID→EX: 1 cycle. Forwarding adds 0 cycles.
- Load-use: exactly 1 stall cycle. On the next cycle the load is in MEM, the consumer re-captures, and it later forwards from MEM/WB.
- Reset mid-stall: stall drops immediately and the bubble state is held until rst deasserts.
- Simultaneous flush+hazard: bubble, stall=0, stall_cnt unchanged.

## Test plan
- After reset, lw $2 then add $3,$2,$2 (rs=rt=2) → stall=1 for 1 cycle, one bubble (ex_valid=0), then add in EX with fwd_a=fwd_b=1 and op_a=op_b=memwb_wt_data=0x0000_00AA; stall_cnt=1.
- exmem (wr=1, addr=5, 0x1111_1111) and memwb (wr=1, addr=5, 0x2222_2222), EX rs=5 → fwd_a=2, ex_op_a=0x1111_1111.
- EX rs=0 with exmem addr=0, wr=1, result 0xDEAD_BEEF → fwd_a=0, ex_op_a=0.
- Load-use hazard with flush=1 the same cycle → stall=0, ex_valid=0 next cycle, stall_cnt unchanged.
- sw-type id_uses_rt=1, rt matches load dest → stall; same with id_uses_rt=0 (addi) → no stall.
- CNT_W=2, 5 consecutive load-use stalls → stall_cnt saturates at 3. Assert rst mid-stall → all outputs 0 without clock edge.
